// File: rtl/decoder_pkg.sv
// Shared types and widths for the sequenced 3-to-8 one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned CODE_W = 32'd3;
  localparam int unsigned OUT_W  = 32'd8;
  localparam int unsigned CNT_W  = 32'd8;

  localparam logic [CNT_W-1:0] CNT_ZERO = 8'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 8'd1;
  localparam logic [OUT_W-1:0] OUT_ZERO = 8'd0;

endpackage

// File: rtl/onehot_dec3to8.sv
// Pure combinational binary-to-one-hot decode; the parent registers the result.
module onehot_dec3to8
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  onehot
);

  // Shift a single set bit into the position selected by code.
  always_comb begin
    onehot = 8'b0000_0001 << code;
  end

endmodule

// File: rtl/decoder3to8_seq.sv
// Accepts a 3-bit code over valid/ready, drives the matching one-hot line for
// HOLD_CYCLES cycles, then idles for GAP_CYCLES cycles before accepting again.
module decoder3to8_seq
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 32'd4,
  parameter int unsigned GAP_CYCLES  = 32'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 32'd1);

  if ((HOLD_CYCLES < 32'd1) || (HOLD_CYCLES > 32'd255)) begin : g_bad_hold
    $error("decoder3to8_seq: HOLD_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES > 32'd255) begin : g_bad_gap
    $error("decoder3to8_seq: GAP_CYCLES must be in 0..255");
  end

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CODE_W-1:0]   code_r;
  logic [CODE_W-1:0]   dec_code;
  logic [OUT_W-1:0]    dec_out;

  // In IDLE the incoming code is decoded so the line appears on the accepting
  // edge; afterwards the latched code keeps the line refreshed.
  assign dec_code   = (state == IDLE) ? code_in : code_r;
  assign code_ready = (state == IDLE) && en && !rst;

  onehot_dec3to8 u_dec (
    .code   (dec_code),
    .onehot (dec_out)
  );

  // Handshake, hold/gap sequencing and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= CNT_ZERO;
      code_r <= 3'd0;
      out    <= OUT_ZERO;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (!en) begin
      // Abort: no done pulse, counter cleared.
      state <= IDLE;
      cnt   <= CNT_ZERO;
      out   <= OUT_ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (code_valid) begin
            code_r <= code_in;
            cnt    <= HOLD_LOAD;
            state  <= DRIVE;
            out    <= dec_out;
            busy   <= 1'b1;
          end else begin
            out  <= OUT_ZERO;
            busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == CNT_ZERO) begin
            out  <= OUT_ZERO;
            done <= 1'b1;
            if (GAP_CYCLES > 32'd0) begin
              cnt   <= GAP_LOAD;
              state <= GAP;
              busy  <= 1'b1;
            end else begin
              cnt   <= CNT_ZERO;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt  <= cnt - CNT_ONE;
            out  <= dec_out;
            done <= 1'b0;
            busy <= 1'b1;
          end
        end
        GAP: begin
          out  <= OUT_ZERO;
          done <= 1'b0;
          if (cnt == CNT_ZERO) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt - CNT_ONE;
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
          out   <= OUT_ZERO;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
